serial_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/serial_rx.sv | 130 +++++++++++++
 tb/tb_serial_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, frame constants and timing helper
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_CLEANUP   = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_D,
  output logic o_Q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_D;
      r_sync <= r_meta;
    end
  end

  assign o_Q = r_sync;

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8N1 UART receiver with byte strobe and framing-error strobe
module serial_rx
  import uart_pkg::*;
#(
  parameter int BAUDRATE        = 115200,
  parameter int CLOCK_FREQUENCY = 48000000
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUDRATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic             w_rx_s;
  uart_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_dv;
  logic             r_ferr;
  logic             r_active;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_D     (i_Rx_Serial),
    .o_Q     (w_rx_s)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_dv      <= 1'b0;
      r_ferr    <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_dv   <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_active  <= 1'b0;
          if (!w_rx_s) begin
            r_state  <= ST_START;
            r_active <= 1'b1;
          end
        end
        ST_START: begin
          // A start bit still low at its midpoint is genuine; otherwise it was noise.
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_bit_idx <= '0;
              r_state   <= ST_DATA;
            end else begin
              r_active <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == IDX_LAST) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
            if (w_rx_s) begin
              r_byte  <= r_shift;
              r_dv    <= 1'b1;
              r_state <= ST_CLEANUP;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= ST_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_CLEANUP: begin
          r_state <= ST_IDLE;
        end
        ST_WAIT_IDLE: begin
          // A break holds the line low; wait for it to rise before hunting again.
          if (w_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_Rx_DV        = r_dv;
  assign o_Rx_Byte      = r_byte;
  assign o_Rx_Frame_Err = r_ferr;
  assign o_Rx_Active    = r_active;

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - scoreboard bench for serial_rx at 10 clocks per bit
`timescale 1ns/1ps
module tb_serial_rx;

  localparam int CLK_NS  = 10;
  localparam int BIT_NS  = 100;

  logic       clk;
  logic       rstn;
  logic       rx;
  logic       dv;
  logic [7:0] rx_byte;
  logic       ferr;
  logic       active;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  bit         ignore_dv = 1'b0;
  bit         saw_c3    = 1'b0;
  int         dv_good   = 0;
  int         dv_cnt    = 0;
  int         ferr_cnt  = 0;
  logic       prev_dv   = 1'b0;
  logic       prev_ferr = 1'b0;
  time        t_dv      = 0;

  serial_rx #(
    .BAUDRATE        (100000),
    .CLOCK_FREQUENCY (1000000)
  ) dut (
    .i_Clock        (clk),
    .i_Rst_n        (rstn),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (dv),
    .o_Rx_Byte      (rx_byte),
    .o_Rx_Frame_Err (ferr),
    .o_Rx_Active    (active)
  );

  initial clk = 1'b0;
  always #(CLK_NS/2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (dv) begin
      dv_cnt++;
      t_dv = $time;
      check("dv_one_cycle", {31'd0, prev_dv}, 32'd0);
      check("dv_ferr_excl", {31'd0, ferr}, 32'd0);
      if (ignore_dv) begin
        if (rx_byte == 8'hC3) saw_c3 = 1'b1;
      end else if (exp_q.size() == 0) begin
        check("dv_unexpected", {24'd0, rx_byte}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        dv_good++;
        check("rx_byte", {24'd0, rx_byte}, {24'd0, e});
      end
    end
    if (ferr) begin
      ferr_cnt++;
      check("ferr_one_cycle", {31'd0, prev_ferr}, 32'd0);
    end
    prev_dv   = dv;
    prev_ferr = ferr;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int bit_ns, input bit push);
    if (push) exp_q.push_back(b);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_v;
    #(bit_ns);
    if (stop_v) rx = 1'b1;
  endtask

  initial begin
    int  d0;
    int  f0;
    int  cnt;
    time t_start;
    int  lat;

    rx   = 1'b1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dv", {31'd0, dv}, 32'd0);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_byte", {24'd0, rx_byte}, 32'd0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);

    // single frame with latency
    d0 = dv_cnt; f0 = ferr_cnt;
    @(posedge clk); #1;
    t_start = $time;
    send_byte(8'hA5, 1'b1, BIT_NS, 1'b1);
    repeat (20) @(posedge clk);
    check("a5_dv_count", dv_cnt - d0, 1);
    check("a5_no_ferr", ferr_cnt - f0, 0);
    lat = int'((t_dv - t_start) / CLK_NS);
    check("a5_latency", {31'd0, (lat >= 94 && lat <= 100)}, 32'd1);

    // back-to-back frames, no idle gap
    d0 = dv_cnt; f0 = ferr_cnt;
    @(posedge clk); #1;
    send_byte(8'h00, 1'b1, BIT_NS, 1'b1);
    send_byte(8'hFF, 1'b1, BIT_NS, 1'b1);
    send_byte(8'h55, 1'b1, BIT_NS, 1'b1);
    send_byte(8'h80, 1'b1, BIT_NS, 1'b1);
    repeat (20) @(posedge clk);
    check("b2b_dv_count", dv_cnt - d0, 4);
    check("b2b_no_ferr", ferr_cnt - f0, 0);

    // 3-clock glitch
    d0 = dv_cnt; f0 = ferr_cnt;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (active) cnt++;
    end
    check("glitch_active_len", {31'd0, (cnt >= 1 && cnt <= 5)}, 32'd1);
    check("glitch_idle", {31'd0, active}, 32'd0);
    check("glitch_no_strobe", (dv_cnt - d0) + (ferr_cnt - f0), 0);
    check("glitch_byte_kept", {24'd0, rx_byte}, 32'h80);

    // framing error then held-low line
    d0 = dv_cnt; f0 = ferr_cnt;
    @(posedge clk); #1;
    send_byte(8'h3C, 1'b0, BIT_NS, 1'b0);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (active) cnt++;
    end
    check("ferr_count", ferr_cnt - f0, 1);
    check("ferr_no_dv", dv_cnt - d0, 0);
    check("ferr_byte_kept", {24'd0, rx_byte}, 32'h80);
    check("break_no_retrigger", cnt, 0);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send_byte(8'h12, 1'b1, BIT_NS, 1'b1);
    repeat (20) @(posedge clk);
    check("after_break_byte", {24'd0, rx_byte}, 32'h12);

    // reset pulse in the middle of bit 4
    ignore_dv = 1'b1;
    @(posedge clk); #1;
    fork
      send_byte(8'hC3, 1'b1, BIT_NS, 1'b0);
      begin
        repeat (55) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_dv", {31'd0, dv}, 32'd0);
        check("midrst_ferr", {31'd0, ferr}, 32'd0);
        check("midrst_active", {31'd0, active}, 32'd0);
        check("midrst_byte", {24'd0, rx_byte}, 32'd0);
        rstn = 1'b1;
      end
    join
    repeat (200) @(posedge clk);
    ignore_dv = 1'b0;
    check("midrst_no_c3", {31'd0, saw_c3}, 32'd0);
    @(posedge clk); #1;
    send_byte(8'h7E, 1'b1, BIT_NS, 1'b1);
    repeat (20) @(posedge clk);
    check("after_rst_byte", {24'd0, rx_byte}, 32'h7E);

    // +/-2% bit period
    f0 = ferr_cnt;
    @(posedge clk); #1;
    send_byte(8'h96, 1'b1, 102, 1'b1);
    repeat (20) @(posedge clk);
    check("slow_byte", {24'd0, rx_byte}, 32'h96);
    @(posedge clk); #1;
    send_byte(8'h96, 1'b1, 98, 1'b1);
    repeat (20) @(posedge clk);
    check("fast_byte", {24'd0, rx_byte}, 32'h96);
    check("tol_no_ferr", ferr_cnt - f0, 0);

    check("queue_drained", exp_q.size(), 0);
    check("good_dv_total", dv_good, 9);
    check("ferr_total", ferr_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
